// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with transmit FIFO and valid/ready input handshake
module uart_tx_param #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   input  logic [DATA_BITS-1:0]               in_data,
   output logic                               in_ready,
   output logic                               tx,
   output logic                               busy,
   output logic                               done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int KW = $clog2(CLKS_PER_BIT);
   localparam logic [KW-1:0] K_LAST = KW'(CLKS_PER_BIT-1);
   localparam logic [3:0] D_LAST = 4'(DATA_BITS-1);
   localparam logic [3:0] S_LAST = 4'(STOP_BITS-1);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   state_t state_q, state_d;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [KW-1:0] cnt_q, cnt_d;
   logic [3:0] bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, head;
   logic par_q, par_d, head_par, tx_d, done_d, push, pop, bit_end, empty;

   assign in_ready = fifo_count != CW'(FIFO_DEPTH);
   assign push     = in_valid && in_ready;
   assign empty    = fifo_count == '0;
   assign head     = mem[rd_ptr];
   assign head_par = (PARITY == 1) ? ~^head : ^head;
   assign busy     = state_q != ST_IDLE;
   assign bit_end  = cnt_q == K_LAST;

   // FIFO storage, written on an accepted handshake
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_data;

   // FIFO pointers and occupancy; a same-edge push and pop leave the count unchanged
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end

   // Next state, bit timing and next line value; the stop bit chains straight into a new start bit
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + KW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               state_d = ST_START;
               tx_d    = 1'b0;
               shift_d = head;
               par_d   = head_par;
            end
         end
         ST_START:
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end
         ST_DATA:
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == D_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                  tx_d    = (PARITY != 0) ? par_q : 1'b1;
               end else begin
                  bit_d = bit_q + 4'd1;
                  tx_d  = shift_q[1];
               end
            end
         ST_PARITY:
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         ST_STOP:
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == S_LAST) begin
                  done_d  = 1'b1;
                  bit_d   = '0;
                  state_d = empty ? ST_IDLE : ST_START;
                  tx_d    = empty;
                  pop     = !empty;
                  shift_d = empty ? shift_q : head;
                  par_d   = empty ? par_q : head_par;
               end else begin
                  bit_d = bit_q + 4'd1;
                  tx_d  = 1'b1;
               end
            end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State and datapath registers; reset forces the line idle and drops the frame in flight
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx      <= 1'b1;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx      <= tx_d;
         done    <= done_d;
      end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with a built-in transmit FIFO and valid/ready input handshake. It generalises the fixed 8N1 transmitter:
- configurable data width, parity mode and stop-bit count
- queues up to FIFO_DEPTH words
- sends queued words back-to-back with no idle gap

It sits between the range-sensor data path and the serial TX pin, so producers no longer wait for the line to go idle.

## Interface
- CLKS_PER_BIT, 87, clk cycles per serial bit (clk freq / baud); legal ≥ 2
- DATA_BITS, 8, data bits per frame; legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥ 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a word on in_data
- in_data  in  DATA_BITS  word to transmit
- in_ready  out  1  FIFO not full; word accepted on an edge where in_valid && in_ready
- tx  out  1  serial line; idle high
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse per completed frame
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words held in the FIFO, excluding the word on the line

## Operation
- Reset values (asynchronous, while rst_n = 0):
  - tx = 1, busy = 0, done = 0, fifo_count = 0
  - FSM in IDLE; FIFO flushed
  - in_ready = 1 (it is combinational from fifo_count), but writes are ignored while rst_n = 0
- FIFO:
  - in_ready = (fifo_count != FIFO_DEPTH)
  - Push and pop on the same edge: fifo_count is unchanged
  - When full, in_ready = 0 even if a pop occurs that edge
  - Pointers wrap modulo FIFO_DEPTH
- Frame format: start (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Parity is computed over the data bits:
  - odd: total number of ones in data + parity is odd
  - even: total number of ones in data + parity is even
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. If FIFO is non-empty, pop the head into the shift register and go to START.
  - START, DATA, PARITY, STOP: each bit is held for exactly CLKS_PER_BIT cycles, using clk_count 0..CLKS_PER_BIT-1.
  - DATA → PARITY when PARITY != 0, otherwise DATA → STOP.
  - STOP: after the last cycle of the last stop bit:
    - if FIFO is non-empty, pop and go directly to START (no idle cycle)
    - otherwise go to IDLE
- done pulses high for exactly one cycle, registered on the edge that ends the final stop bit. It fires whether the next state is IDLE or START.
- Reset asserted mid-frame: tx goes to 1 immediately; the partial frame and all queued words are discarded.

## Timing
- Latency from empty and idle: word accepted at edge E0; FSM pops at E1; tx = 0 from E1.
- Frame length = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles.
- Back-to-back frames: the next start bit begins on the same edge that ends the previous stop bit.
- tx is registered: no combinational path from any input to tx.
- fifo_count updates on the edge after the push or pop.

## Test plan
1. Config CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2 (even), STOP_BITS=1. Push 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles (44 cycles total); done pulses once at cycle 44; busy high throughout.
2. PARITY=1 (odd), DATA_BITS=7, STOP_BITS=2. Push 0x07 → tx = 0,1,1,1,0,0,0,0,0,1,1; parity bit is 0; frame is 11 bits × 4 = 44 cycles.
3. FIFO_DEPTH=4, in_valid held high with 0x11, 0x22, 0x33, 0x44, 0x55 → first word pops at E1, four more are accepted, then in_ready drops at fifo_count=4. All five frames go out back-to-back with no tx-high gap between a stop bit and the next start bit; done pulses 5 times, 40 cycles apart (8N1 at CLKS_PER_BIT=4).
4. Simultaneous push and pop: FIFO holds 2 words, push on the edge the STOP state pops → fifo_count stays 2.
5. Assert rst_n low mid-way through data bit 3 of a frame with 3 words queued → tx = 1 and fifo_count = 0 immediately. After release: busy = 0, in_ready = 1, and no frame is sent until a new push.
6. Push 0x00 with PARITY=0, STOP_BITS=1 → 9 low bits followed by 1 high bit (40 cycles at CLKS_PER_BIT=4); after done, tx stays 1 and busy = 0.
